// File: rtl/localmem_pkg.sv
// Shared definitions for the local memory writer: memory geometry defaults,
// the mode encoding and the FSM state encoding.
package localmem_pkg;

  localparam int LM_WIDTH     = 24;
  localparam int LM_NUM_BANKS = 4;
  localparam int LM_BANK_SEL  = 2;
  localparam int LM_ADDR_W    = 10;

  localparam logic MODE_BURST = 1'b0;
  localparam logic MODE_SEQ   = 1'b1;

  typedef logic [1:0] lm_state_t;

  localparam lm_state_t ST_IDLE  = 2'd0;
  localparam lm_state_t ST_RUN   = 2'd1;
  localparam lm_state_t ST_FLUSH = 2'd2;
  localparam lm_state_t ST_FIN   = 2'd3;

endpackage

// File: rtl/localmem_addr_gen.sv
// Address generation for the local memory writer: row counter for BURST,
// linear counter for SEQ (bit-reversed when LOCALMEM_BITREV_EN is defined),
// and sticky wrap detection. Counters persist across frames; only reset clears them.
module localmem_addr_gen
  import localmem_pkg::*;
#(
  parameter int ADDR_W   = LM_ADDR_W,
  parameter int BANK_SEL = LM_BANK_SEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_ovf,
  input  logic              row_inc,
  input  logic              seq_inc,
  output logic [ADDR_W-1:0] row_addr,
  output logic [ADDR_W-1:0] seq_addr,
  output logic              overflow
);

  localparam int ROW_W = ADDR_W - BANK_SEL;

  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] seq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q    <= '0;
      seq_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (row_inc) row_q <= row_q + ROW_W'(1);
      if (seq_inc) seq_q <= seq_q + ADDR_W'(1);
      // A wrap seen in the same cycle as a clear wins, so no wrap is lost.
      if ((row_inc && (&row_q)) || (seq_inc && (&seq_q)))
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign row_addr = {row_q, {BANK_SEL{1'b0}}};

`ifdef LOCALMEM_BITREV_EN
  always_comb begin
    seq_addr = '0;
    for (int b = 0; b < ADDR_W; b++) seq_addr[b] = seq_q[ADDR_W-1-b];
  end
`else
  assign seq_addr = seq_q;
`endif

endmodule

// File: rtl/localmem_writer.sv
// Streams complex samples into a banked local memory, either row-packed (BURST)
// or one sample per write (SEQ). Optional macro: LOCALMEM_BITREV_EN (bit-reversed SEQ addresses).
//
// Handshake: a sample transfers on a rising edge where s_valid && s_ready; s_ready
// depends only on registered state, never on s_valid, and upstream holds s_data stable while s_valid waits.
module localmem_writer
  import localmem_pkg::*;
#(
  parameter int width     = LM_WIDTH,
  parameter int NUM_BANKS = LM_NUM_BANKS,
  parameter int BANK_SEL  = LM_BANK_SEL,
  parameter int ADDR_W    = LM_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [ADDR_W:0]            frame_len,
  input  logic                       s_valid,
  input  logic [width-1:0]           s_data,
  output logic                       s_ready,
  output logic                       CSB,
  output logic                       WEB,
  output logic                       OEB,
  output logic [ADDR_W-1:0]          A,
  output logic [NUM_BANKS*width-1:0] I,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [1:0]                 state_dbg
);

  lm_state_t state_q, state_d;
  logic      mode_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] count_q;
  logic [NUM_BANKS-1:0][width-1:0] slot_q;
  logic [NUM_BANKS-1:0][width-1:0] slot_nxt;
  logic [BANK_SEL-1:0] slot_idx;
  logic [ADDR_W-1:0]   row_addr;
  logic [ADDR_W-1:0]   seq_addr;
  logic start_go, accept, seq_go, burst_last, partial, frame_end, flush_go;

  assign start_go   = (state_q == ST_IDLE) && start;
  assign frame_end  = (state_q == ST_RUN) && (count_q == len_q);
  assign s_ready    = (state_q == ST_RUN) && (count_q != len_q);
  assign accept     = s_valid && s_ready;
  assign slot_idx   = count_q[BANK_SEL-1:0];
  assign seq_go     = accept && (mode_q == MODE_SEQ);
  assign burst_last = accept && (mode_q == MODE_BURST) &&
                      (slot_idx == BANK_SEL'(NUM_BANKS - 1));
  // A BURST frame that ends mid-row leaves a partial row to flush.
  assign partial    = (mode_q == MODE_BURST) && (len_q[BANK_SEL-1:0] != '0);
  assign flush_go   = frame_end && partial;

  always_comb begin
    slot_nxt           = slot_q;
    slot_nxt[slot_idx] = s_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (count_q == len_q) state_d = partial ? ST_FLUSH : ST_FIN;
      ST_FLUSH: state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BURST;
      len_q   <= '0;
      count_q <= '0;
      slot_q  <= '0;
      CSB     <= 1'b1;
      WEB     <= 1'b1;
      A       <= '0;
      I       <= '0;
    end else begin
      state_q <= state_d;
      CSB     <= 1'b1;
      WEB     <= 1'b1;
      if (start_go) begin
        mode_q  <= mode;
        len_q   <= frame_len;
        count_q <= '0;
        slot_q  <= '0;
      end
      if (accept) begin
        count_q <= count_q + (ADDR_W+1)'(1);
        if (seq_go) begin
          CSB <= 1'b0;
          WEB <= 1'b0;
          A   <= seq_addr;
          I   <= {NUM_BANKS{s_data}};
        end else if (burst_last) begin
          CSB    <= 1'b0;
          WEB    <= 1'b0;
          A      <= row_addr;
          I      <= slot_nxt;
          slot_q <= '0;
        end else begin
          slot_q <= slot_nxt;
        end
      end
      // Slots are cleared after every row, so unfilled slots are already zero here.
      if (flush_go) begin
        CSB    <= 1'b0;
        WEB    <= 1'b0;
        A      <= row_addr;
        I      <= slot_q;
        slot_q <= '0;
      end
    end
  end

  localmem_addr_gen #(
    .ADDR_W  (ADDR_W),
    .BANK_SEL(BANK_SEL)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clr_ovf (start_go),
    .row_inc (burst_last || flush_go),
    .seq_inc (seq_go),
    .row_addr(row_addr),
    .seq_addr(seq_addr),
    .overflow(overflow)
  );

  assign OEB       = 1'b1;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign state_dbg = state_q;

endmodule
